// File: rtl/autoenc_pkg.sv
// Shared types and constants for the autoencoder memory-select path.
// State encoding for the bank sequencer plus select-register width.
package autoenc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    NEXT,
    DONE
  } state_t;

  localparam int SEL_W     = 4;
  localparam int MAX_BANKS = 16;

endpackage

// File: rtl/mem_sel_cnt.sv
// Compute-window cycle counter with clear, enable and terminal flag.
// Wraps to zero on the enabled cycle where the terminal flag is set.
module mem_sel_cnt #(
  parameter int LEN = 8,
  parameter int W   = $clog2(LEN + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(LEN - 1);

  logic [W-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_sel_seq.sv
// Bank sequencer feeding the memory-select register (load + compute window).
// Optional abort input enabled by defining MEM_SEL_SEQ_ABORT_EN.
module mem_sel_seq
  import autoenc_pkg::*;
#(
  parameter int NUM_BANKS   = 10,
  parameter int BANK_CYCLES = 8,
  parameter int CNT_W       = $clog2(BANK_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
`ifdef MEM_SEL_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [SEL_W-1:0] sel_code,
  output logic             sel_load,
  output logic             compute_en,
  output logic             busy,
  output logic             done
);

  generate
    if (NUM_BANKS < 1 || NUM_BANKS > MAX_BANKS) begin : g_bad_banks
      $error("mem_sel_seq: NUM_BANKS out of range");
    end
    if (BANK_CYCLES < 1) begin : g_bad_cycles
      $error("mem_sel_seq: BANK_CYCLES must be >= 1");
    end
  endgenerate

  localparam logic [SEL_W-1:0] LAST_BANK = SEL_W'(NUM_BANKS - 1);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] bank, bank_nxt;
  logic             ab;
  logic             tc;
  logic             cnt_clr;
  logic             cnt_en;

`ifdef MEM_SEL_SEQ_ABORT_EN
  assign ab = abort && (state != IDLE);
`else
  assign ab = 1'b0;
`endif

  assign cnt_clr = (state != RUN) || ab;
  assign cnt_en  = (state == RUN) && !hold;

  mem_sel_cnt #(
    .LEN (BANK_CYCLES),
    .W   (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      bank  <= '0;
    end else begin
      state <= state_nxt;
      bank  <= bank_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bank_nxt  = bank;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          bank_nxt  = '0;
        end
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        if (!hold && tc) state_nxt = NEXT;
      end
      NEXT: begin
        if (bank == LAST_BANK) begin
          state_nxt = DONE;
        end else begin
          state_nxt = LOAD;
          bank_nxt  = bank + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        bank_nxt  = '0;
      end
      default: begin
        state_nxt = IDLE;
        bank_nxt  = '0;
      end
    endcase
    // abort outranks every other transition
    if (ab) begin
      state_nxt = IDLE;
      bank_nxt  = '0;
    end
  end

  always_comb begin
    sel_code   = bank;
    sel_load   = 1'b0;
    compute_en = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (1'b1)
      (state == IDLE): busy       = 1'b0;
      (state == LOAD): sel_load   = 1'b1;
      (state == RUN):  compute_en = !hold;
      (state == DONE): done       = 1'b1;
      default: ;
    endcase
  end

endmodule
